// File: rtl/pe_ctrl.sv
// pe_ctrl: sequencer in front of the PE datapath. Pulls (activation, filter)
// beats off a valid/ready stream, drives PE regfile writes, mux selects and
// arithmetic strobes, waits on PE completion bits, and commits the result of
// one conv dot product (bias + taps) or one max-pool window.
module pe_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TAP_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [TAP_W-1:0]      num_taps,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_actn,
  input  logic [DATA_WIDTH-1:0] in_filt,
  output logic [DATA_WIDTH-1:0] actn_in,
  output logic [DATA_WIDTH-1:0] filt_in,
  output logic                  actn_in_sel,
  output logic                  wt_in_sel,
  output logic                  add_in_sel,
  output logic                  pe_out_sel,
  output logic                  if_rf_wr_en,
  output logic                  wt_rf_wr_en,
  output logic                  of_rf_wr_en,
  output logic                  acc_wr_en,
  output logic                  mult_en,
  output logic                  mult_load,
  output logic                  add_en,
  output logic                  acc_clr,
  input  logic [1:0]            pe_resp,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [4:0] {
    IDLE, CLR,
    B_LD, B_WR, B_ADD, B_ACC,
    T_LD, T_WR, M_LD, M_RUN, A_RUN, ACC,
    P_LD, P_WR, P_CMP,
    O_WR, DONE, ERR
  } state_t;

  state_t            state_reg, state_next;
  logic              mode_reg;
  logic [TAP_W-1:0]  num_reg;
  logic [TAP_W-1:0]  tap_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic              err_reg;

  logic              wait_state;
  logic              resp_hit;
  logic              timeout_hit;
  logic [TAP_W:0]    tap_inc;
  logic              more_taps;
  logic              xfer;

  // Response bits only matter in the three wait states; the watchdog fires on
  // the TIMEOUT-th consecutive cycle without the awaited bit.
  always_comb begin
    wait_state  = (state_reg == B_ADD) || (state_reg == M_RUN) || (state_reg == A_RUN);
    resp_hit    = ((state_reg == B_ADD) && pe_resp[1]) ||
                  ((state_reg == M_RUN) && pe_resp[0]) ||
                  ((state_reg == A_RUN) && pe_resp[1]);
    timeout_hit = wait_state && !resp_hit && (wait_reg == WAIT_LAST);
    // Compare one bit wider so a full 2**TAP_W-1 window never wraps.
    tap_inc     = {1'b0, tap_reg} + (TAP_W + 1)'(1);
    more_taps   = tap_inc < {1'b0, num_reg};
    xfer        = in_valid && in_ready;
  end

  // State register, latched op parameters, counters and the PE input registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      mode_reg  <= 1'b0;
      num_reg   <= '0;
      tap_reg   <= '0;
      wait_reg  <= '0;
      err_reg   <= 1'b0;
      actn_in   <= '0;
      filt_in   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        mode_reg <= mode;
        num_reg  <= num_taps;
        err_reg  <= 1'b0;
      end
      if (timeout_hit) err_reg <= 1'b1;
      if (state_reg == CLR) tap_reg <= '0;
      else if (state_reg == ACC || state_reg == P_CMP) tap_reg <= tap_inc[TAP_W-1:0];
      wait_reg <= (wait_state && !resp_hit) ? wait_reg + WAIT_W'(1) : '0;
      // Bias beats carry no activation; pool beats carry no weight.
      if (xfer && (state_reg == T_LD || state_reg == P_LD)) actn_in <= in_actn;
      if (xfer && (state_reg == T_LD || state_reg == B_LD)) filt_in <= in_filt;
    end
  end

  // Next-state logic and Moore decode of every PE control output.
  always_comb begin
    state_next  = state_reg;
    in_ready    = 1'b0;
    actn_in_sel = 1'b0;
    pe_out_sel  = 1'b0;
    wt_in_sel   = 1'b0;
    add_in_sel  = 1'b0;
    if_rf_wr_en = 1'b0;
    wt_rf_wr_en = 1'b0;
    of_rf_wr_en = 1'b0;
    acc_wr_en   = 1'b0;
    mult_en     = 1'b0;
    mult_load   = 1'b0;
    add_en      = 1'b0;
    acc_clr     = 1'b0;
    done        = 1'b0;
    busy        = (state_reg != IDLE);
    err         = err_reg;

    // Mode selects are held for the whole op; the bias path selects cover the
    // whole bias sub-sequence so they do not toggle mid-operation.
    if (state_reg != IDLE) begin
      actn_in_sel = mode_reg;
      pe_out_sel  = mode_reg;
    end
    if (state_reg == B_LD || state_reg == B_WR || state_reg == B_ADD || state_reg == B_ACC) begin
      wt_in_sel  = 1'b1;
      add_in_sel = 1'b1;
    end

    case (state_reg)
      IDLE:  if (start) state_next = CLR;
      CLR: begin
        acc_clr = 1'b1;
        if (!mode_reg)          state_next = B_LD;
        else if (num_reg == '0) state_next = O_WR;
        else                    state_next = P_LD;
      end
      B_LD: begin
        in_ready = 1'b1;
        if (in_valid) state_next = B_WR;
      end
      B_WR: begin
        wt_rf_wr_en = 1'b1;
        state_next  = B_ADD;
      end
      B_ADD: begin
        add_en = 1'b1;
        if (resp_hit)         state_next = B_ACC;
        else if (timeout_hit) state_next = ERR;
      end
      B_ACC: begin
        acc_wr_en  = 1'b1;
        state_next = (num_reg != '0) ? T_LD : O_WR;
      end
      T_LD: begin
        in_ready = 1'b1;
        if (in_valid) state_next = T_WR;
      end
      T_WR: begin
        if_rf_wr_en = 1'b1;
        wt_rf_wr_en = 1'b1;
        state_next  = M_LD;
      end
      M_LD: begin
        mult_load  = 1'b1;
        state_next = M_RUN;
      end
      M_RUN: begin
        mult_en = 1'b1;
        if (resp_hit)         state_next = A_RUN;
        else if (timeout_hit) state_next = ERR;
      end
      A_RUN: begin
        add_en = 1'b1;
        if (resp_hit)         state_next = ACC;
        else if (timeout_hit) state_next = ERR;
      end
      ACC: begin
        acc_wr_en  = 1'b1;
        state_next = more_taps ? T_LD : O_WR;
      end
      P_LD: begin
        in_ready = 1'b1;
        if (in_valid) state_next = P_WR;
      end
      P_WR: begin
        if_rf_wr_en = 1'b1;
        state_next  = P_CMP;
      end
      P_CMP: state_next = more_taps ? P_LD : O_WR;
      O_WR: begin
        of_rf_wr_en = 1'b1;
        state_next  = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_ctrl.sv
// tb_pe_ctrl: directed bench for pe_ctrl with a small behavioural PE stub.
// Expected of_regfile results are queued when an op is launched and popped
// when the controller strobes of_rf_wr_en.
module tb_pe_ctrl;
  localparam int DW = 8;
  localparam int TW = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst, start, mode, in_valid, in_ready;
  logic [TW-1:0] num_taps;
  logic [DW-1:0] in_actn, in_filt, actn_in, filt_in;
  logic          actn_in_sel, wt_in_sel, add_in_sel, pe_out_sel;
  logic          if_rf_wr_en, wt_rf_wr_en, of_rf_wr_en, acc_wr_en;
  logic          mult_en, mult_load, add_en, acc_clr;
  logic [1:0]    pe_resp;
  logic          busy, done, err;

  always #5 clk = ~clk;

  pe_ctrl #(.DATA_WIDTH(DW), .TAP_W(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_taps(num_taps),
    .in_valid(in_valid), .in_ready(in_ready), .in_actn(in_actn), .in_filt(in_filt),
    .actn_in(actn_in), .filt_in(filt_in),
    .actn_in_sel(actn_in_sel), .wt_in_sel(wt_in_sel), .add_in_sel(add_in_sel), .pe_out_sel(pe_out_sel),
    .if_rf_wr_en(if_rf_wr_en), .wt_rf_wr_en(wt_rf_wr_en), .of_rf_wr_en(of_rf_wr_en), .acc_wr_en(acc_wr_en),
    .mult_en(mult_en), .mult_load(mult_load), .add_en(add_en), .acc_clr(acc_clr),
    .pe_resp(pe_resp), .busy(busy), .done(done), .err(err)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {busy, done, err, in_ready, actn_in, filt_in,
            actn_in_sel, wt_in_sel, add_in_sel, pe_out_sel,
            if_rf_wr_en, wt_rf_wr_en, of_rf_wr_en, acc_wr_en,
            mult_en, mult_load, add_en, acc_clr};
  endfunction

  // PE stub: responds one cycle after each strobe, unless the mult reply is withheld.
  logic        hold_mult;
  logic [7:0]  if_rf, wt_rf;
  logic [15:0] prod, sum, acc, pool_max;
  always @(posedge clk) begin
    if (!rst) pe_resp <= 2'b00;
    else begin
      pe_resp[0] <= mult_en & ~pe_resp[0] & ~hold_mult;
      pe_resp[1] <= add_en & ~pe_resp[1];
    end
    if (if_rf_wr_en) if_rf <= actn_in;
    if (wt_rf_wr_en) wt_rf <= filt_in;
    if (mult_en) prod <= 16'(if_rf) * 16'(wt_rf);
    if (add_en) sum <= acc + (add_in_sel ? 16'(wt_rf) : prod);
    if (acc_clr) begin
      acc      <= 16'd0;
      pool_max <= 16'd0;
    end else begin
      if (acc_wr_en) acc <= sum;
      if (if_rf_wr_en && actn_in_sel && 16'(actn_in) > pool_max) pool_max <= 16'(actn_in);
    end
  end

  // Scoreboard and event counters.
  typedef struct { logic m; logic [15:0] val; } exp_t;
  exp_t sb[$];
  int done_cnt = 0, ifwr_cnt = 0, mult_hi = 0, add_hi = 0, hs_cnt = 0;

  always @(posedge clk) if (in_valid && in_ready) hs_cnt++;

  always @(negedge clk) begin
    exp_t e;
    if (done)        done_cnt++;
    if (if_rf_wr_en) ifwr_cnt++;
    if (mult_en)     mult_hi++;
    if (add_en)      add_hi++;
    if (of_rf_wr_en) begin
      chk("of_wr_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("of_pe_out_sel", 32'(pe_out_sel), 32'(e.m));
        chk("of_actn_in_sel", 32'(actn_in_sel), 32'(e.m));
        chk("of_value", 32'(pe_out_sel ? pool_max : acc), 32'(e.val));
      end
    end
  end

  task automatic do_start(input logic m, input logic [TW-1:0] n);
    mode = m; num_taps = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // kind 0 = bias beat, 1 = conv tap, 2 = pool beat
  task automatic send(input logic [7:0] a, input logic [7:0] f, input int kind);
    int n = 0;
    logic [7:0] pa, pf;
    in_actn = a; in_filt = f; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("beat_ready", 32'(in_ready), 32'd1);
    pa = actn_in; pf = filt_in;
    @(negedge clk);
    in_valid = 1'b0;
    case (kind)
      0: begin
        chk("bias_filt_in", 32'(filt_in), 32'(f));
        chk("bias_actn_kept", 32'(actn_in), 32'(pa));
        chk("bias_wt_wr", 32'({wt_rf_wr_en, wt_in_sel, if_rf_wr_en}), 32'b110);
      end
      1: begin
        chk("tap_actn_in", 32'(actn_in), 32'(a));
        chk("tap_filt_in", 32'(filt_in), 32'(f));
        chk("tap_wr", 32'({if_rf_wr_en, wt_rf_wr_en, wt_in_sel}), 32'b110);
      end
      default: begin
        chk("pool_actn_in", 32'(actn_in), 32'(a));
        chk("pool_filt_kept", 32'(filt_in), 32'(pf));
        chk("pool_if_wr", 32'({if_rf_wr_en, wt_rf_wr_en}), 32'b10);
      end
    endcase
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 500) begin @(negedge clk); n++; end
    chk(tag, 32'(done), 32'd1);
    @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int d0, i0, m0, a0, h0, n, mx;
    logic [7:0] v;
    rst = 1'b0; start = 1'b0; mode = 1'b0; num_taps = '0;
    in_valid = 1'b0; in_actn = '0; in_filt = '0; hold_mult = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // conv, 2 taps: 5 + 3*4 + 2*7 = 31
    d0 = done_cnt;
    sb.push_back('{1'b0, 16'd31});
    do_start(1'b0, 4'd2);
    send(8'hAA, 8'd5, 0);
    send(8'd3, 8'd4, 1);
    send(8'd2, 8'd7, 1);
    wait_done("conv2_done");
    repeat (3) @(negedge clk);
    chk("conv2_done_once", 32'(done_cnt - d0), 32'd1);

    // pool, 3 taps: max(9,2,14) = 14, no arithmetic strobes
    i0 = ifwr_cnt; m0 = mult_hi; a0 = add_hi;
    sb.push_back('{1'b1, 16'd14});
    do_start(1'b1, 4'd3);
    send(8'd9, 8'h55, 2);
    send(8'd2, 8'h66, 2);
    send(8'd14, 8'h77, 2);
    wait_done("pool3_done");
    chk("pool3_if_wr_pulses", 32'(ifwr_cnt - i0), 32'd3);
    chk("pool3_no_mult", 32'(mult_hi - m0), 32'd0);
    chk("pool3_no_add", 32'(add_hi - a0), 32'd0);

    // in_valid toggling 1,0,0,1: only two transfers
    sb.push_back('{1'b1, 16'd20});
    do_start(1'b1, 4'd2);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("tog_ready", 32'(in_ready), 32'd1);
    h0 = hs_cnt;
    in_actn = 8'd20; in_valid = 1'b1; @(negedge clk);
    chk("tog_actn_c1", 32'(actn_in), 32'd20);
    in_actn = 8'd11; in_valid = 1'b0; @(negedge clk);
    chk("tog_actn_c2", 32'(actn_in), 32'd20);
    @(negedge clk);
    chk("tog_actn_c3", 32'(actn_in), 32'd20);
    in_valid = 1'b1; @(negedge clk);
    chk("tog_actn_c4", 32'(actn_in), 32'd11);
    in_valid = 1'b0;
    wait_done("tog_done");
    chk("tog_transfers", 32'(hs_cnt - h0), 32'd2);

    // watchdog: mult reply withheld
    hold_mult = 1'b1;
    d0 = done_cnt;
    do_start(1'b0, 4'd1);
    send(8'd0, 8'd1, 0);
    send(8'd1, 8'd1, 1);
    m0 = mult_hi;
    n = 0;
    while (!err && n < 300) begin @(negedge clk); n++; end
    chk("to_err_set", 32'(err), 32'd1);
    chk("to_wait_cycles", 32'(mult_hi - m0), 32'(TO));
    repeat (10) @(negedge clk);
    do_start(1'b0, 4'd1);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 32'({err, busy, mult_en, add_en, in_ready}), 32'b11000);
    chk("to_no_done", 32'(done_cnt - d0), 32'd0);
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    hold_mult = 1'b0;
    chk("to_reset_clears", 32'({err, busy}), 32'd0);
    sb.push_back('{1'b0, 16'd17});
    do_start(1'b0, 4'd1);
    send(8'd0, 8'd2, 0);
    send(8'd3, 8'd5, 1);
    wait_done("to_recover_done");
    chk("to_recover_err", 32'(err), 32'd0);

    // reset in the middle of a multiply
    hold_mult = 1'b1;
    do_start(1'b0, 4'd1);
    send(8'd0, 8'd4, 0);
    send(8'd5, 8'd5, 1);
    n = 0;
    while (!mult_en && n < 20) begin @(negedge clk); n++; end
    chk("mid_mult_en", 32'(mult_en), 32'd1);
    rst = 1'b0; @(negedge clk);
    chk("mid_reset_outputs", all_outs(), 32'd0);
    rst = 1'b1; hold_mult = 1'b0;
    sb.push_back('{1'b0, 16'd7});
    do_start(1'b0, 4'd1);
    send(8'd0, 8'd1, 0);
    send(8'd2, 8'd3, 1);
    wait_done("mid_fresh_done");

    // conv, 0 taps, bias 6, with start pulsed while busy
    d0 = done_cnt; a0 = add_hi;
    sb.push_back('{1'b0, 16'd6});
    do_start(1'b0, 4'd0);
    do_start(1'b1, 4'd5);
    send(8'd0, 8'd6, 0);
    wait_done("conv0_done");
    repeat (4) @(negedge clk);
    chk("conv0_done_once", 32'(done_cnt - d0), 32'd1);
    chk("conv0_add_cycles", 32'(add_hi - a0), 32'd2);
    chk("conv0_stays_idle", 32'(busy), 32'd0);

    // pool with the largest window 2**TAP_W-1
    i0 = ifwr_cnt; mx = 0;
    for (int k = 0; k < 15; k++) begin
      v = 8'((k * 37 + 11) % 256);
      if (int'(v) > mx) mx = int'(v);
    end
    sb.push_back('{1'b1, 16'(mx)});
    do_start(1'b1, 4'd15);
    for (int k = 0; k < 15; k++) begin
      v = 8'((k * 37 + 11) % 256);
      send(v, 8'd0, 2);
    end
    wait_done("pool15_done");
    chk("pool15_if_wr_pulses", 32'(ifwr_cnt - i0), 32'd15);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
